// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types, constants and the round-robin search helper used by the
// AXI-Stream arbiter and any other arbiter that wants the same fairness rule.
//   arb_state_e  : FSM states {IDLE, LOCKED}
//   BEAT_CNT_W   : width of the per-grant beat counter
//   MAX_SRC      : largest supported requester count
//   rr_next()    : next requester searching upward from last+1, wrapping
// -----------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int BEAT_CNT_W = 8;
    localparam int MAX_SRC    = 16;

    // valid_vec is zero-padded above the real requester count. Because the
    // padding bits are never set, wrapping at MAX_SRC visits the real
    // requesters in exactly the same order as wrapping at NUM_SRC would.
    // Returns 'last' when nothing requests (caller checks the any flag).
    function automatic logic [3:0] rr_next(input logic [MAX_SRC-1:0] valid_vec,
                                           input logic [3:0]         last);
        logic [3:0] idx;
        rr_next = last;
        // Walk farthest-to-nearest so the nearest hit overwrites the result;
        // k = MAX_SRC lands on 'last' itself, which is lowest priority.
        for (int k = MAX_SRC; k >= 1; k--) begin
            idx = last + 4'(k);
            if (valid_vec[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Pure combinational round-robin pick: first asserted request searching
// upward from last_i+1, modulo NUM_SRC.
//   req_i  [NUM_SRC]  request vector
//   last_i [IDW]      most recently granted index
//   next_o [IDW]      index to grant next (meaningful only when any_o)
//   any_o             at least one request asserted
// -----------------------------------------------------------------------------
module rr_priority_picker
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDW     = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [IDW-1:0]     next_o,
    output logic               any_o
);

    logic [MAX_SRC-1:0] req_ext;
    logic [3:0]         next_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = req_i;
        next_ext               = rr_next(req_ext, 4'(last_i));
    end

    assign next_o = IDW'(next_ext);
    assign any_o  = |req_i;

endmodule

// File: rtl/axis_stream_arbiter.sv
// -----------------------------------------------------------------------------
// axis_stream_arbiter
// Shares one AXI-Stream consumer between NUM_SRC producers. A grant is held
// until the granted packet ends (TLAST beat accepted) or MAX_BURST beats have
// passed, then priority rotates round-robin. Data path is combinational while
// LOCKED; a release costs one IDLE bubble cycle for re-arbitration.
//   clk, resetn           clock, async active-low reset
//   S_AXIS_TDATA/TVALID/TLAST/TREADY   producer side, source i at [i*DW +: DW]
//   M_AXIS_TDATA/TVALID/TLAST/TREADY   consumer side
//   grant_id              current or most recent granted source
//   grant_active          high while LOCKED
// TLAST is passed through untouched: a burst-limit release splits a packet
// and the remainder arrives on a later grant, possibly interleaved.
// -----------------------------------------------------------------------------
module axis_stream_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DW        = 512,
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_SRC*DW-1:0]      S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]         S_AXIS_TVALID,
    input  logic [NUM_SRC-1:0]         S_AXIS_TLAST,
    output logic [NUM_SRC-1:0]         S_AXIS_TREADY,
    output logic [DW-1:0]              M_AXIS_TDATA,
    output logic                       M_AXIS_TVALID,
    output logic                       M_AXIS_TLAST,
    input  logic                       M_AXIS_TREADY,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       grant_active
);

    localparam int IDW = $clog2(NUM_SRC);
    localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(MAX_BURST - 1);

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [IDW-1:0]        last_q,  last_d;
    logic [BEAT_CNT_W-1:0] cnt_q,   cnt_d;

    logic [IDW-1:0]        pick;
    logic                  pick_any;
    logic                  beat;

    rr_priority_picker #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW)
    ) u_picker (
        .req_i  (S_AXIS_TVALID),
        .last_i (last_q),
        .next_o (pick),
        .any_o  (pick_any)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NUM_SRC - 1);   // source 0 wins the first round
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        S_AXIS_TREADY = '0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        beat          = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                M_AXIS_TDATA           = S_AXIS_TDATA[int'(grant_q)*DW +: DW];
                M_AXIS_TVALID          = S_AXIS_TVALID[grant_q];
                M_AXIS_TLAST           = S_AXIS_TLAST[grant_q];
                S_AXIS_TREADY[grant_q] = M_AXIS_TREADY;
                beat                   = M_AXIS_TVALID & M_AXIS_TREADY;
                if (beat) begin
                    cnt_d = cnt_q + BEAT_CNT_W'(1);
                    // Either condition alone releases; both together is
                    // still a single release.
                    if (M_AXIS_TLAST || (cnt_q == BURST_LAST)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id     = grant_q;
    assign grant_active = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_stream_arbiter.sv
module tb_axis_stream_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int MB = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N*DW-1:0]   s_tdata;
    logic [N-1:0]      s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid, m_tlast, m_tready;
    logic [1:0]        grant_id;
    logic              grant_active;

    always #5 clk = ~clk;

    axis_stream_arbiter #(.DW(DW), .NUM_SRC(N), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .grant_id      (grant_id),
        .grant_active  (grant_active)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Producer beat queues: {last, data}
    logic [DW:0] srcq [N][$];
    int          gate [N];      // cycles a source forces its valid low
    int          hold;          // cycles the consumer forces ready low
    bit          rnd_v, rnd_r;

    // Reference model: which source owns the consumer, how many beats it has
    // had, and who owned it last.
    bit m_locked;
    int m_gid, m_last, m_cnt;

    int          log_src [$];
    bit          log_last[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input int len);
        logic [DW-1:0] d;
        for (int k = 0; k < len; k++) begin
            d = DW'($urandom());
            srcq[s].push_back({(k == len - 1) ? 1'b1 : 1'b0, d});
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 0;
        return 1;
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance model.
    task automatic step();
        logic [DW:0]   h;
        logic [N-1:0]  e_rdy;
        logic [DW-1:0] e_d;
        bit            e_v, e_l, v, found;
        int            c;
        for (int i = 0; i < N; i++) begin
            v = (srcq[i].size() != 0) && (gate[i] == 0) &&
                (!rnd_v || ($urandom_range(3) != 0));
            h = v ? srcq[i][0] : '0;
            s_tvalid[i]           = v;
            s_tdata[i*DW +: DW]   = h[DW-1:0];
            s_tlast[i]            = h[DW];
            if (gate[i] > 0) gate[i]--;
        end
        if (hold > 0) begin m_tready = 1'b0; hold--; end
        else m_tready = rnd_r ? ($urandom_range(2) != 0) : 1'b1;

        @(negedge clk);
        e_v = 0; e_l = 0; e_d = '0; e_rdy = '0;
        if (m_locked) begin
            e_v = s_tvalid[m_gid];
            if (e_v) begin
                h   = srcq[m_gid][0];
                e_d = h[DW-1:0];
                e_l = h[DW];
            end
            e_rdy[m_gid] = m_tready;
        end
        chk("grant_active", grant_active, m_locked);
        chk("grant_id", grant_id, m_gid);
        chk("m_tvalid", m_tvalid, e_v);
        chk("m_tlast", m_tlast, e_l);
        chk("m_tdata", m_tdata, e_d);
        chk("s_tready", s_tready, e_rdy);

        if (!m_locked) begin
            if (s_tvalid != 0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && s_tvalid[c]) begin m_gid = c; found = 1; end
                end
                m_locked = 1; m_cnt = 0;
            end
        end else if (e_v && m_tready) begin
            log_src.push_back(m_gid);
            log_last.push_back(e_l);
            void'(srcq[m_gid].pop_front());
            m_cnt++;
            if (e_l || m_cnt == MB) begin m_locked = 0; m_last = m_gid; end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget, output int cyc);
        cyc = 0;
        while (!(all_empty() && !m_locked) && cyc < budget) begin
            step();
            cyc++;
        end
        chk("drain_timeout", (cyc < budget) ? 1 : 0, 1);
    endtask

    task automatic clear_log();
        log_src.delete(); log_last.delete();
    endtask

    initial begin
        int cyc;
        int exp_src;
        for (int i = 0; i < N; i++) gate[i] = 0;
        hold = 0; rnd_v = 0; rnd_r = 0;
        model_reset();

        // Reset state with every input asserted
        resetn   = 1'b0;
        s_tvalid = '1; s_tlast = '1; s_tdata = '1; m_tready = 1'b1;
        #12;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_grant_active", grant_active, 0);
        s_tvalid = '0;
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Single source 2, 3-beat packet
        clear_log();
        push(2, 3);
        step();
        chk("s1_grant_id", grant_id, 2);
        chk("s1_grant_active", grant_active, 1);
        drain(100, cyc);
        chk("s1_beats", log_src.size(), 3);
        for (int k = 0; k < log_src.size(); k++) begin
            chk("s1_src", log_src[k], 2);
            chk("s1_last", log_last[k], (k == 2) ? 1 : 0);
        end

        // All sources valid, 1-beat packets: rotate from last grant (2)
        clear_log();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 1);
        drain(200, cyc);
        chk("rr_cycles", cyc, 16);
        chk("rr_beats", log_src.size(), 8);
        for (int k = 0; k < log_src.size(); k++) chk("rr_order", log_src[k], (3 + k) % N);

        // 40-beat packet on source 1 split by the burst limit around source 3
        clear_log();
        push(1, 40);
        step();
        push(3, 3);
        drain(500, cyc);
        chk("burst_beats", log_src.size(), 43);
        for (int k = 0; k < log_src.size(); k++) begin
            exp_src = (k >= 16 && k < 19) ? 3 : 1;
            chk("burst_src", log_src[k], exp_src);
            chk("burst_last", log_last[k], (k == 18 || k == 42) ? 1 : 0);
        end

        // Consumer backpressure for 5 cycles mid-packet
        clear_log();
        push(0, 4);
        step(); step(); step();
        hold = 5;
        drain(100, cyc);
        chk("bp_beats", log_src.size(), 4);
        chk("bp_cycles", cyc, 7);

        // Granted source drops valid for 3 cycles while another waits
        clear_log();
        push(0, 4);
        step(); step();
        gate[0] = 3;
        push(2, 2);
        drain(100, cyc);
        chk("gap_beats", log_src.size(), 6);
        for (int k = 0; k < log_src.size(); k++) chk("gap_src", log_src[k], (k < 4) ? 0 : 2);

        // Randomized traffic with random valid/ready
        rnd_v = 1; rnd_r = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) != 0) push(i, $urandom_range(1, 40));
            drain(5000, cyc);
        end
        rnd_v = 0; rnd_r = 0;

        // Asynchronous reset during beat 2 of a 4-beat packet
        push(3, 4);
        step(); step();
        #2 resetn = 1'b0;
        #1;
        chk("arst_s_tready", s_tready, 0);
        chk("arst_grant_active", grant_active, 0);
        chk("arst_m_tvalid", m_tvalid, 0);
        chk("arst_grant_id", grant_id, 0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        model_reset();
        s_tvalid = '0;
        @(negedge clk); #2 resetn = 1'b1;
        @(posedge clk); #1;
        clear_log();
        push(1, 2);
        push(0, 2);
        drain(100, cyc);
        chk("arst_beats", log_src.size(), 4);
        if (log_src.size() > 0) chk("arst_first_src", log_src[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_stream_arbiter.md
# axis_stream_arbiter

Round-robin arbiter that shares one AXI-Stream consumer (e.g. `data_consumer` or a downstream FIFO/DMA sink) between `NUM_SRC` AXI-Stream producers. It grants one producer at a time and holds the grant until that producer's packet ends (TLAST beat accepted) or a burst limit is reached. On release it rotates priority fairly. It sits between the producer fan-in and the single consumer in the receive datapath.

## Interface
Parameters:
- `DW`, 512, data width of every stream.
- `NUM_SRC`, 4, number of producers (2..16).
- `MAX_BURST`, 16, maximum beats per grant before forced rotation (1..255).

Ports:
- `clk`  in  1  single clock for the whole block.
- `resetn`  in  1  reset, asynchronous and active-low.
- `S_AXIS_TDATA`  in  NUM_SRC*DW  producer data; source i occupies bits [i*DW +: DW].
- `S_AXIS_TVALID`  in  NUM_SRC  producer valid, one bit per source.
- `S_AXIS_TLAST`  in  NUM_SRC  producer end-of-packet, one bit per source.
- `S_AXIS_TREADY`  out  NUM_SRC  producer ready, one bit per source.
- `M_AXIS_TDATA`  out  DW  data to consumer.
- `M_AXIS_TVALID`  out  1  valid to consumer.
- `M_AXIS_TLAST`  out  1  end-of-packet to consumer.
- `M_AXIS_TREADY`  in  1  ready from consumer.
- `grant_id`  out  clog2(NUM_SRC)  index of the currently or most recently granted source.
- `grant_active`  out  1  high while in LOCKED.

## Operation
- Two-state FSM: IDLE, LOCKED.
- IDLE: all `S_AXIS_TREADY`=0 and `M_AXIS_TVALID`=0. If any `S_AXIS_TVALID` is high, choose the first asserted source searching upward from `last_grant+1` modulo NUM_SRC. Register it into `grant_id`, clear the beat counter, and go to LOCKED.
- LOCKED: combinational pass-through from source `grant_id`:
  - `M_AXIS_TDATA/TVALID/TLAST` = granted source's signals.
  - `S_AXIS_TREADY[grant_id]` = `M_AXIS_TREADY`.
  - All other `S_AXIS_TREADY` bits = 0.
- Beat = `M_AXIS_TVALID & M_AXIS_TREADY` in LOCKED. Each beat increments the 8-bit beat counter.
- Release to IDLE after a beat when either:
  - the beat has TLAST=1, or
  - the counter reaches MAX_BURST (counter == MAX_BURST-1 before the increment).
- On release, `last_grant` <= `grant_id`. If both release conditions are true in the same beat, it is a single release.
- TLAST is never modified. A burst-limit release mid-packet passes the packet remainder on a later grant. Downstream tolerates interleaving; this is documented, not masked.
- Granted source dropping TVALID between beats: stay LOCKED, no timeout.
- Sources whose TVALID is low are skipped in arbitration. A source with valid high is granted within NUM_SRC arbitration rounds (starvation-free).

## Timing
- Reset values: FSM=IDLE, `grant_id`=0, `last_grant`=NUM_SRC-1 (source 0 wins first), beat counter=0, `grant_active`=0.
- Resulting output reset values: all `S_AXIS_TREADY`=0, `M_AXIS_TVALID`=0, `M_AXIS_TLAST`=0, `M_AXIS_TDATA`=0 (driven 0 in IDLE).
- Arbitration latency: 1 cycle. Valid seen in IDLE at cycle N gives the grant and first possible beat at cycle N+1.
- Release costs one bubble cycle in IDLE. Sustained throughput per grant is MAX_BURST/(MAX_BURST+1) beats per cycle.
- Input-to-output path is combinational in LOCKED. There is no output register, so the consumer sees zero added latency per beat.
- `resetn` low mid-packet: returns to IDLE immediately (asynchronous) and drops all readys the same instant. The partial packet is the producer's responsibility.

## Structure
- Package `axis_arb_pkg`:
  - FSM state enum {IDLE, LOCKED}.
  - Beat-counter width constant (8).
  - Function `rr_next(valid_vec, last)` returning the next source index.
- One natural sub-module: `rr_priority_picker` (pure combinational). Inputs: request vector and last grant. Outputs: next index and an any-request flag. It is reusable by other arbiters in the design.

## Test plan
- Single source 2, 3-beat packet (TLAST on beat 3), consumer always ready -> grant_id=2 one cycle after valid; 3 beats on M with identical data; returns to IDLE; `last_grant`=2.
- All 4 sources continuously valid, 1-beat packets -> grant order 0,1,2,3,0…; one beat every 2 cycles.
- Source 1 sends a 40-beat packet while source 3 is valid, MAX_BURST=16 -> beats 1–16 from source 1; then source 3's packet; then source 1 resumes at beat 17; TLAST only on source 1's 40th beat.
- Consumer backpressure: `M_AXIS_TREADY` low for 5 cycles mid-packet -> M data held stable, granted S_AXIS_TREADY low, beat counter unchanged, no duplicated or lost beats.
- `resetn` pulsed low during beat 2 of a 4-beat packet -> all readys 0 asynchronously; after release, arbitration restarts with source 0 priority.
- Granted source drops TVALID for 3 cycles between beats while another source is valid -> grant held; no switch until TLAST.
